// File: rtl/mdu_pkg.sv
// mdu_pkg
//   Shared definitions for the RV32M multiply/divide sequencing controller:
//   funct3 encodings of the M extension, the controller FSM state type,
//   and the architectural results used for division special cases.
package mdu_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[2] separates the divide/remainder group from the multiply group.
  function automatic logic is_div_op(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/mdu_fixup.sv
// mdu_fixup
//   Combinational resolver for the RV32M division corner cases. It is
//   compiled only when MDU_FIXUP_EN is defined.
//   Ports:
//     rs1, rs2     in  32  registered operands
//     funct3       in  3   registered M-extension funct3
//     is_special   out 1   operands hit divide-by-zero or signed overflow
//     special_val  out 32  architectural result for that case
`ifdef MDU_FIXUP_EN
import mdu_pkg::*;

module mdu_fixup (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  output logic        is_special,
  output logic [31:0] special_val
);

  // Divide by zero applies to all four divide ops; the INT_MIN / -1
  // overflow only applies to the signed pair DIV/REM.
  always_comb begin
    is_special  = 1'b0;
    special_val = '0;
    if (is_div_op(funct3)) begin
      if (rs2 == '0) begin
        is_special  = 1'b1;
        special_val = (funct3 == MD_REM || funct3 == MD_REMU) ? rs1 : DIV0_Q;
      end else if ((funct3 == MD_DIV || funct3 == MD_REM) &&
                   rs1 == INT_MIN && rs2 == 32'hFFFF_FFFF) begin
        is_special  = 1'b1;
        special_val = (funct3 == MD_DIV) ? INT_MIN : 32'h0;
      end
    end
  end

endmodule
`endif

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl
//   Sequencing front-end for a combinational RV32M multiply/divide unit.
//   Accepts one op, holds its operands steady on the MDU for a fixed
//   settle window (MUL_CYCLES or DIV_CYCLES), captures the result and
//   offers it to writeback. At most one op is in flight.
//   Optional build macro: MDU_FIXUP_EN resolves divide-by-zero and signed
//   overflow in the controller, returning the fixed value after one cycle.
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     req_valid/req_ready          issue handshake
//     req_rs1/rs2/funct3/rd        op operands, funct3, destination
//     flush                        aborts any in-flight op
//     mdu_rs1/rs2/function3        registered values driving the MDU
//     mdu_result                   combinational MDU result
//     rsp_valid/rsp_ready          writeback handshake
//     rsp_data/rsp_rd              captured result and destination
//     busy                         controller is not idle
import mdu_pkg::*;

module mdu_seq_ctrl #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] mdu_rs1,
  output logic [31:0] mdu_rs2,
  output logic [2:0]  mdu_function3,
  input  logic [31:0] mdu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             cap_now;
  logic [31:0]      cap_val;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

  // A flush in the same cycle as an offered op means the op is refused.
  assign accept = req_valid && req_ready && !flush;

`ifdef MDU_FIXUP_EN
  logic        is_special;
  logic [31:0] special_val;

  // Special cases are judged on the registered operands, so the fixed
  // value is ready after the first EXEC cycle.
  mdu_fixup u_fixup (
    .rs1         (mdu_rs1),
    .rs2         (mdu_rs2),
    .funct3      (mdu_function3),
    .is_special  (is_special),
    .special_val (special_val)
  );

  assign cap_now = (cnt == '0) || is_special;
  assign cap_val = is_special ? special_val : mdu_result;
`else
  assign cap_now = (cnt == '0);
  assign cap_val = mdu_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Flush overrides every transition; a response handshaken together with
  // a flush is simply treated as consumed.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (req_valid) state_nxt = EXEC;
        EXEC: if (cap_now) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
        DONE: if (rsp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operands stay frozen from accept until the next accept so the MDU
  // output settles; the counter sets the settle window per op class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_rs1       <= '0;
      mdu_rs2       <= '0;
      mdu_function3 <= '0;
      rsp_data      <= '0;
      rsp_rd        <= '0;
      cnt           <= '0;
    end else if (accept) begin
      mdu_rs1       <= req_rs1;
      mdu_rs2       <= req_rs2;
      mdu_function3 <= req_funct3;
      rsp_rd        <= req_rd;
      cnt           <= is_div_op(req_funct3) ? DIV_LOAD : MUL_LOAD;
    end else if (capture) begin
      rsp_data <= cap_val;
    end else if (state == EXEC) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl
//   Self-checking bench for mdu_seq_ctrl. A behavioural RV32M model stands in
//   for the combinational MDU; it returns a marker value for the divide corner
//   cases so that controller-side resolution (MDU_FIXUP_EN) is distinguishable
//   from pass-through. Expected results and latencies come from plain
//   arithmetic on the requested operands.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic [2:0]  mdu_function3;
  logic [31:0] mdu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] RAW_MARK = 32'hDEAD_BEEF;

  mdu_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_funct3    (req_funct3),
    .req_rd        (req_rd),
    .flush         (flush),
    .mdu_rs1       (mdu_rs1),
    .mdu_rs2       (mdu_rs2),
    .mdu_function3 (mdu_function3),
    .mdu_result    (mdu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_rd        (rsp_rd),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Architectural RV32M result; signed division done on magnitudes so no
  // host-side signed overflow can occur.
  function automatic logic [31:0] rv32m(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    logic [63:0] p;
    logic [63:0] sa, sb;
    logic [31:0] ma, mb, q, rm, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = (mb == 0) ? 32'h0 : ma / mb;
    rm = (mb == 0) ? 32'h0 : ma % mb;
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * {32'h0, b}; r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a[31] ^ b[31]) ? -q : q);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (a[31] ? -rm : rm);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f);
    if (f < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] raw_mdu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    return is_special(a, b, f) ? RAW_MARK : rv32m(a, b, f);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
`ifdef MDU_FIXUP_EN
    return rv32m(a, b, f);
`else
    return raw_mdu(a, b, f);
`endif
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f);
`ifdef MDU_FIXUP_EN
    if (is_special(a, b, f)) return 1;
`endif
    return (f >= 3'd4) ? 4 : 1;
  endfunction

  assign mdu_result = raw_mdu(mdu_rs1, mdu_rs2, mdu_function3);

  // Offers one op at a negedge with the DUT idle, then waits for rsp_valid.
  // cyc=k means rsp_valid first seen in cycle T+k. Returns at that negedge
  // with rsp_ready low.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                          input logic [4:0] rd, input bit noise,
                          output int cyc, output bit ready_seen);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b; req_funct3 = f; req_rd = rd;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; ready_seen = 1'b0;
    while (cyc < 40) begin
      if (rsp_valid) break;
      if (req_ready) ready_seen = 1'b1;
      if (noise) begin
        req_valid = 1'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
        req_funct3 = 3'($urandom); req_rd = 5'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    checks++;
    if ({mdu_rs1, mdu_rs2, mdu_function3, rsp_data, rsp_rd} !== '0) begin
      fails++; $display("[TB] FAIL reset_regs: mdu_rs1=%h mdu_rs2=%h f3=%h data=%h rd=%0d, want all 0",
                        mdu_rs1, mdu_rs2, mdu_function3, rsp_data, rsp_rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_ready: req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_mul();
    int cyc; bit seen;
    start_op(32'd7, -32'sd3, 3'd0, 5'd5, 1'b0, cyc, seen);
    checks++;
    if (cyc !== 2) begin fails++; $display("[TB] FAIL mul_latency: cycle T+%0d, want T+2", cyc); end
    checks++;
    if (rsp_data !== 32'hFFFF_FFEB || rsp_rd !== 5'd5) begin
      fails++; $display("[TB] FAIL mul_result: data=%h rd=%0d, want ffffffeb 5", rsp_data, rsp_rd);
    end
    checks++;
    if (mdu_rs1 !== 32'd7 || mdu_function3 !== 3'd0) begin
      fails++; $display("[TB] FAIL mul_operands: mdu_rs1=%h f3=%0d, want 7 0", mdu_rs1, mdu_function3);
    end
    finish_rsp();
  endtask

  task automatic test_divu();
    int cyc; bit seen;
    start_op(32'd100, 32'd7, 3'd5, 5'd9, 1'b0, cyc, seen);
    checks++;
    if (cyc !== 5 || seen !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL divu_timing: valid at T+%0d ready_seen=%b ready=%b, want T+5 0 0",
                        cyc, seen, req_ready);
    end
    checks++;
    if (rsp_data !== 32'd14 || rsp_rd !== 5'd9) begin
      fails++; $display("[TB] FAIL divu_result: data=%0d rd=%0d, want 14 9", rsp_data, rsp_rd);
    end
    finish_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL divu_return: req_ready=%b rsp_valid=%b at T+6, want 1 0",
                        req_ready, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit seen; bit stable;
    start_op(-32'sd7, 32'd2, 3'd6, 5'd3, 1'b0, cyc, seen);
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_rd !== 5'd3) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
      fails++; $display("[TB] FAIL rem_hold: data=%h stable=%b, want ffffffff 1", rsp_data, stable);
    end
    finish_rsp();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL rem_idle: busy=%b req_ready=%b, want 0 1", busy, req_ready);
    end
  endtask

  task automatic test_special();
    logic [31:0] a [4] = '{32'd55, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  f [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    int cyc; bit seen;
    for (int i = 0; i < 4; i++) begin
      start_op(a[i], b[i], f[i], 5'(i + 20), 1'b0, cyc, seen);
      checks++;
      if (cyc !== exp_lat(a[i], b[i], f[i]) + 1 || rsp_data !== exp_data(a[i], b[i], f[i])) begin
        fails++; $display("[TB] FAIL special_%0d: valid at T+%0d data=%h, want T+%0d %h", i, cyc,
                          rsp_data, exp_lat(a[i], b[i], f[i]) + 1, exp_data(a[i], b[i], f[i]));
      end
      finish_rsp();
    end
  endtask

  task automatic test_flush();
    int cyc; bit seen; bit any_valid;
    req_valid = 1'b1; req_rs1 = 32'd1000; req_rs2 = 32'd10; req_funct3 = 3'd4; req_rd = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_exec: rsp_valid=%b busy=%b ready=%b, want 0 0 1",
                        rsp_valid, busy, req_ready);
    end
    any_valid = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) any_valid = 1'b1; end
    checks++;
    if (any_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_no_rsp: saw rsp_valid=1, want none"); end
    start_op(32'hFFFF_FFFF, 32'd2, 3'd3, 5'd7, 1'b0, cyc, seen);
    checks++;
    if (cyc !== 2 || rsp_data !== 32'd1 || rsp_rd !== 5'd7) begin
      fails++; $display("[TB] FAIL flush_next_mulhu: T+%0d data=%h rd=%0d, want T+2 1 7", cyc, rsp_data, rsp_rd);
    end
    finish_rsp();
    // flush together with an offered op: not accepted
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_req: busy=%b, want 0", busy); end
    // flush while a response waits, with and without rsp_ready
    for (int k = 0; k < 2; k++) begin
      start_op(32'd3, 32'd4, 3'd0, 5'd2, 1'b0, cyc, seen);
      flush = 1'b1; rsp_ready = 1'(k);
      @(negedge clk);
      flush = 1'b0; rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("[TB] FAIL flush_done_%0d: rsp_valid=%b ready=%b, want 0 1", k, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_async_reset();
    bit any_valid;
    req_valid = 1'b1; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_funct3 = 3'd5; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mdu_rs1 !== '0 || rsp_data !== '0 || rsp_rd !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL async_reset: mdu_rs1=%h data=%h rd=%0d busy=%b valid=%b, want all 0",
                        mdu_rs1, rsp_data, rsp_rd, busy, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) any_valid = 1'b1; end
    checks++;
    if (any_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL async_reset_after: saw_valid=%b ready=%b, want 0 1", any_valid, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, e;
    logic [2:0]  f;
    logic [4:0]  rd;
    int cyc, hold, sel; bit seen;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 9));
      hold = $urandom_range(0, 2);
      e = exp_data(a, b, f);
      start_op(a, b, f, rd, 1'b1, cyc, seen);
      checks++;
      if (cyc !== exp_lat(a, b, f) + 1 || seen !== 1'b0) begin
        fails++; $display("[TB] FAIL rand_%0d_timing: f3=%0d T+%0d ready_seen=%b, want T+%0d 0",
                          i, f, cyc, seen, exp_lat(a, b, f) + 1);
      end
      checks++;
      if (rsp_data !== e || rsp_rd !== rd) begin
        fails++; $display("[TB] FAIL rand_%0d_data: f3=%0d a=%h b=%h got %h rd=%0d, want %h rd=%0d",
                          i, f, a, b, rsp_data, rsp_rd, e, rd);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_rd !== rd) begin
          fails++; $display("[TB] FAIL rand_%0d_hold: valid=%b data=%h, want 1 %h", i, rsp_valid, rsp_data, e);
        end
      end
      finish_rsp();
      checks++;
      if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rand_%0d_ready: req_ready=%b, want 1", i, req_ready); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_mul();
    test_divu();
    test_backpressure();
    test_special();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
